aes_word_sequencer: RTL and testbench



---
 rtl/aes_seq_pkg.sv | 30 +++
 rtl/aes_timeout_counter.sv | 30 +++
 rtl/aes_word_sequencer.sv | 128 ++++++++++++
 tb/tb_aes_word_sequencer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES word sequencer.
// Combinational helpers only; no state, no latency, no flow control.
package aes_seq_pkg;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;

    typedef enum logic [2:0] {
        COLLECT,
        ISSUE,
        WAIT,
        CAPTURE,
        DRAIN
    } state_t;

    // Word 0 is the most significant word of the block.
    function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                     input logic [1:0]         idx);
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_timeout_counter.sv
// Watchdog for the WAIT state: held at zero by clr, counts while en, tc at TIMEOUT_CYCLES-1.
// Registered count, tc decoded from it; no flow control.
module aes_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int            CW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_cnt <= '0;
        end else if (clr) begin
            tmo_cnt <= '0;
        end else if (en) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    assign tc = (tmo_cnt == TC_VAL);

endmodule

// File: rtl/aes_word_sequencer.sv
// Packs 4 words into an AES block, runs one core request with watchdog, streams 4 result words out.
// All outputs registered; last input word to first output word is 4 cycles minimum; drain waits on out_ready.
module aes_word_sequencer
    import aes_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [WORD_W-1:0]   word_in,
    input  logic                word_valid,
    output logic                word_ready,
    input  logic                mode_in,
    output logic                aes_enable,
    output logic                aes_enc_req,
    output logic                aes_dec_req,
    output logic [BLOCK_W-1:0]  aes_data_in,
    input  logic [BLOCK_W-1:0]  aes_data_out,
    input  logic                aes_data_ready,
    output logic [WORD_W-1:0]   word_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                timeout_err,
    output logic [15:0]         blocks_done
);

    localparam logic [1:0] LAST_IDX = 2'(WORDS_PER_BLOCK - 1);

    state_t             state, state_nx;
    logic [1:0]         word_cnt;
    logic [1:0]         rd_idx;
    logic               mode_r;
    logic [BLOCK_W-1:0] result_r;
    logic               tmo_tc;
    logic               in_hs;
    logic               out_hs;
    logic               abort;
    logic               req_nx;

    assign in_hs  = word_valid & word_ready;
    assign out_hs = out_valid & out_ready;
    // Completion takes priority over the watchdog in the same cycle.
    assign abort  = (state == WAIT) & ~aes_data_ready & tmo_tc;
    assign req_nx = (state_nx == ISSUE) | (state_nx == WAIT);

    aes_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (state != WAIT),
        .en    (state == WAIT),
        .tc    (tmo_tc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: if (in_hs && word_cnt == LAST_IDX) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT: begin
                if (aes_data_ready) begin
                    state_nx = CAPTURE;
                end else if (tmo_tc) begin
                    state_nx = COLLECT;
                end
            end
            CAPTURE: state_nx = DRAIN;
            DRAIN:   if (out_hs && rd_idx == LAST_IDX) state_nx = COLLECT;
            default: state_nx = COLLECT;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            word_ready  <= 1'b1;
            aes_enable  <= 1'b0;
            aes_enc_req <= 1'b0;
            aes_dec_req <= 1'b0;
            aes_data_in <= '0;
            word_out    <= '0;
            out_valid   <= 1'b0;
            timeout_err <= 1'b0;
            blocks_done <= '0;
            word_cnt    <= '0;
            rd_idx      <= '0;
            mode_r      <= 1'b0;
            result_r    <= '0;
        end else begin
            word_ready  <= (state_nx == COLLECT);
            aes_enable  <= (state_nx == ISSUE);
            aes_enc_req <= req_nx & mode_r;
            aes_dec_req <= req_nx & ~mode_r;
            out_valid   <= (state_nx == DRAIN);
            timeout_err <= abort;

            if (in_hs) begin
                aes_data_in <= {aes_data_in[BLOCK_W-WORD_W-1:0], word_in};
                word_cnt    <= word_cnt + 2'd1;
                if (word_cnt == 2'd0) begin
                    mode_r <= mode_in;
                end
            end else if (abort) begin
                word_cnt <= '0;
            end

            if (state == CAPTURE) begin
                result_r    <= aes_data_out;
                blocks_done <= blocks_done + 16'd1;
                rd_idx      <= '0;
                word_out    <= block_word(aes_data_out, 2'd0);
            end else if (out_hs) begin
                rd_idx   <= rd_idx + 2'd1;
                word_out <= block_word(result_r, rd_idx + 2'd1);
            end
        end
    end

endmodule

// File: tb/tb_aes_word_sequencer.sv
// Bench for aes_word_sequencer: behavioural core model plus a queue of expected output words.
module tb_aes_word_sequencer;

    localparam int           TMO  = 16;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    localparam logic [127:0] KX   = 128'h5a5a5a5a0123456789abcdeff0e1d2c3;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic [31:0]  word_in = '0;
    logic         word_valid = 1'b0;
    logic         word_ready;
    logic         mode_in = 1'b0;
    logic         aes_enable;
    logic         aes_enc_req;
    logic         aes_dec_req;
    logic [127:0] aes_data_in;
    logic [127:0] aes_data_out = JUNK;
    logic         aes_data_ready = 1'b0;
    logic [31:0]  word_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         timeout_err;
    logic [15:0]  blocks_done;

    int total = 0;
    int bad = 0;
    int exp_blocks = 0;
    int enable_count = 0;
    int tmo_count = 0;
    logic [31:0] exp_q[$];

    int           core_lat = 10;
    bit           core_never = 1'b0;
    bit           core_early = 1'b0;
    int           core_cnt = -1;
    bit           core_pend = 1'b0;
    logic [127:0] core_res = '0;

    always #5 clk = ~clk;

    aes_word_sequencer #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .word_in        (word_in),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .mode_in        (mode_in),
        .aes_enable     (aes_enable),
        .aes_enc_req    (aes_enc_req),
        .aes_dec_req    (aes_dec_req),
        .aes_data_in    (aes_data_in),
        .aes_data_out   (aes_data_out),
        .aes_data_ready (aes_data_ready),
        .word_out       (word_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .timeout_err    (timeout_err),
        .blocks_done    (blocks_done)
    );

    // Known-answer for the FIPS-197 vector, a reversible stand-in cipher for everything else.
    function automatic logic [127:0] core_fn(input logic [127:0] blk, input logic enc);
        logic [127:0] x;
        if (enc && blk == PT) return CT;
        if (!enc && blk == CT) return PT;
        if (enc) return {blk[119:0], blk[127:120]} ^ KX;
        x = blk ^ KX;
        return {x[7:0], x[127:8]};
    endfunction

    // Core model: ready core_lat cycles after the enable pulse, data valid the cycle after ready.
    always @(negedge clk or negedge n_rst) begin
        if (!n_rst) begin
            core_cnt       = -1;
            core_pend      = 1'b0;
            aes_data_ready = 1'b0;
            aes_data_out   = JUNK;
        end else begin
            aes_data_ready = 1'b0;
            aes_data_out   = core_pend ? core_res : JUNK;
            core_pend      = 1'b0;
            if (aes_enable === 1'b1) begin
                core_res = core_fn(aes_data_in, aes_enc_req);
                core_cnt = core_never ? -1 : core_lat;
                if (core_early) aes_data_ready = 1'b1;
            end else if (core_cnt > 0) begin
                core_cnt = core_cnt - 1;
                if (core_cnt == 0) begin
                    aes_data_ready = 1'b1;
                    core_pend      = 1'b1;
                    core_cnt       = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (aes_enable === 1'b1) enable_count = enable_count + 1;
        if (timeout_err === 1'b1) tmo_count = tmo_count + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t exceeded, want finish earlier", $time);
        $fatal(1);
    end

    // Feeds one block; returns at the negedge of the ISSUE cycle and checks the request there.
    task automatic send_block(input logic [127:0] blk, input logic mode, input bit expect_out);
        logic [127:0] res;
        int guard;
        if (expect_out) begin
            res = core_fn(blk, mode);
            for (int i = 0; i < 4; i++) exp_q.push_back(res[(3-i)*32 +: 32]);
        end
        for (int i = 0; i < 4; i++) begin
            word_in    = blk[(3-i)*32 +: 32];
            mode_in    = (i == 0) ? mode : ~mode;
            word_valid = 1'b1;
            guard      = 0;
            while (word_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            total++;
            if (guard >= 50) begin
                bad++;
                $display("FAIL send_word_ready: got %b want 1", word_ready);
            end
            @(negedge clk);
        end
        word_valid = 1'b0;
        word_in    = '0;
        total++;
        if (aes_enable !== 1'b1) begin
            bad++;
            $display("FAIL issue_enable: got %b want 1", aes_enable);
        end
        total++;
        if (aes_data_in !== blk) begin
            bad++;
            $display("FAIL issue_data_in: got %h want %h", aes_data_in, blk);
        end
        total++;
        if ({aes_enc_req, aes_dec_req} !== {mode, ~mode}) begin
            bad++;
            $display("FAIL issue_req: got enc=%b dec=%b want enc=%b dec=%b",
                     aes_enc_req, aes_dec_req, mode, ~mode);
        end
    endtask

    // Pops and compares each accepted word; with toggle, out_ready alternates 0/1.
    task automatic drain_block(input bit toggle);
        int          got = 0;
        int          guard = 0;
        bit          held = 1'b0;
        bit          phase = 1'b0;
        logic [31:0] held_w = '0;
        logic [31:0] exp_w;
        while (got < 4 && guard < 200) begin
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || word_out !== held_w) begin
                    bad++;
                    $display("FAIL drain_hold: got valid=%b word=%h want valid=1 word=%h",
                             out_valid, word_out, held_w);
                end
            end
            held = 1'b0;
            if (out_valid === 1'b1) begin
                total++;
                if (word_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL drain_word_ready: got %b want 0", word_ready);
                end
                out_ready = toggle ? phase : 1'b1;
                phase     = ~phase;
                if (out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL drain_extra: got word %h want none", word_out);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (word_out !== exp_w) begin
                            bad++;
                            $display("FAIL drain_word%0d: got %h want %h", got, word_out, exp_w);
                        end
                    end
                    got++;
                end else begin
                    held   = 1'b1;
                    held_w = word_out;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        exp_blocks++;
        total++;
        if (got != 4) begin
            bad++;
            $display("FAIL drain_count: got %0d words want 4", got);
        end
        total++;
        if (out_valid !== 1'b0 || word_ready !== 1'b1) begin
            bad++;
            $display("FAIL drain_end: got valid=%b ready=%b want valid=0 ready=1", out_valid, word_ready);
        end
        total++;
        if (blocks_done !== 16'(exp_blocks)) begin
            bad++;
            $display("FAIL blocks_done: got %0d want %0d", blocks_done, 16'(exp_blocks));
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if (word_ready !== 1'b1 || aes_enable !== 1'b0 || aes_enc_req !== 1'b0 ||
            aes_dec_req !== 1'b0 || out_valid !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got rdy=%b en=%b enc=%b dec=%b ov=%b te=%b want 1 0 0 0 0 0",
                     word_ready, aes_enable, aes_enc_req, aes_dec_req, out_valid, timeout_err);
        end
        total++;
        if (aes_data_in !== '0 || word_out !== '0 || blocks_done !== '0) begin
            bad++;
            $display("FAIL reset_data: got din=%h wo=%h bd=%h want 0", aes_data_in, word_out, blocks_done);
        end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips_encrypt;
        int e0 = enable_count;
        core_lat = 10;
        send_block(PT, 1'b1, 1'b1);
        @(negedge clk);
        total++;
        if (aes_enable !== 1'b0 || aes_enc_req !== 1'b1) begin
            bad++;
            $display("FAIL enc_pulse_width: got en=%b enc=%b want en=0 enc=1", aes_enable, aes_enc_req);
        end
        drain_block(1'b0);
        total++;
        if (enable_count - e0 != 1) begin
            bad++;
            $display("FAIL enc_enable_count: got %0d want 1", enable_count - e0);
        end
    endtask

    task automatic test_decrypt;
        send_block(CT, 1'b0, 1'b1);
        drain_block(1'b0);
    endtask

    task automatic test_timeout;
        int n = 0;
        core_never = 1'b1;
        send_block(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b1, 1'b0);
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == TMO) begin
                total++;
                if (aes_enc_req !== 1'b1) begin
                    bad++;
                    $display("FAIL tmo_req_held: got %b want 1", aes_enc_req);
                end
            end
            if (timeout_err === 1'b1) break;
        end
        total++;
        if (n != TMO + 1) begin
            bad++;
            $display("FAIL tmo_latency: got %0d cycles want %0d", n, TMO + 1);
        end
        total++;
        if (word_ready !== 1'b1 || aes_enc_req !== 1'b0 || blocks_done !== 16'(exp_blocks)) begin
            bad++;
            $display("FAIL tmo_state: got rdy=%b enc=%b bd=%0d want rdy=1 enc=0 bd=%0d",
                     word_ready, aes_enc_req, blocks_done, 16'(exp_blocks));
        end
        @(negedge clk);
        total++;
        if (timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_pulse_width: got %b want 0", timeout_err);
        end
        core_never = 1'b0;
        core_lat   = 4;
        send_block(128'h11112222333344445555666677778888, 1'b1, 1'b1);
        drain_block(1'b0);
    endtask

    task automatic test_backpressure;
        core_lat = 3;
        send_block(128'hcafef00d0badc0de1234567889abcdef, 1'b0, 1'b1);
        drain_block(1'b1);
    endtask

    task automatic test_back_to_back;
        int k = 0;
        core_lat = 1;
        send_block(128'ha5a5a5a5b6b6b6b6c7c7c7c7d8d8d8d8, 1'b1, 1'b1);
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (out_valid === 1'b1) break;
        end
        total++;
        if (k != 3) begin
            bad++;
            $display("FAIL turnaround: got first out_valid %0d cycles after issue want 3", k);
        end
        drain_block(1'b0);
        send_block(128'h0123456789abcdeffedcba9876543210, 1'b0, 1'b1);
        drain_block(1'b0);
    endtask

    task automatic test_ready_on_last_wait;
        int t0 = tmo_count;
        core_lat = TMO;
        send_block(128'h99887766554433221100ffeeddccbbaa, 1'b1, 1'b1);
        drain_block(1'b0);
        total++;
        if (tmo_count != t0) begin
            bad++;
            $display("FAIL ready_beats_timeout: got %0d timeout pulses want 0", tmo_count - t0);
        end
    endtask

    task automatic test_ready_in_issue;
        core_early = 1'b1;
        core_lat   = 3;
        send_block(128'h13579bdf2468ace0fdb97531eca86420, 1'b1, 1'b1);
        @(negedge clk);
        total++;
        if (aes_enc_req !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL issue_ready_ignored: got enc=%b ov=%b want enc=1 ov=0", aes_enc_req, out_valid);
        end
        core_early = 1'b0;
        drain_block(1'b0);
    endtask

    task automatic test_reset_mid_wait;
        core_never = 1'b1;
        send_block(128'hfeedfacefeedfacefeedfacefeedface, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        total++;
        if (aes_enc_req !== 1'b0 || aes_dec_req !== 1'b0 || aes_enable !== 1'b0 ||
            out_valid !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_ctrl: got enc=%b dec=%b en=%b ov=%b te=%b want all 0",
                     aes_enc_req, aes_dec_req, aes_enable, out_valid, timeout_err);
        end
        total++;
        if (aes_data_in !== '0 || word_out !== '0 || blocks_done !== '0) begin
            bad++;
            $display("FAIL rst_data: got din=%h wo=%h bd=%0d want 0", aes_data_in, word_out, blocks_done);
        end
        @(negedge clk);
        n_rst      = 1'b1;
        exp_blocks = 0;
        core_never = 1'b0;
        core_lat   = 5;
        @(negedge clk);
        total++;
        if (word_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_release_ready: got %b want 1", word_ready);
        end
        send_block(128'h00000001000000020000000300000004, 1'b1, 1'b1);
        drain_block(1'b0);
    endtask

    task automatic test_wrap;
        force dut.blocks_done = 16'hffff;
        @(posedge clk);
        #1 release dut.blocks_done;
        @(negedge clk);
        exp_blocks = 65535;
        total++;
        if (blocks_done !== 16'hffff) begin
            bad++;
            $display("FAIL wrap_preload: got %h want ffff", blocks_done);
        end
        core_lat = 2;
        send_block(128'h0badf00d0badf00d0badf00d0badf00d, 1'b0, 1'b1);
        drain_block(1'b0);
    endtask

    initial begin
        test_reset();
        test_fips_encrypt();
        test_decrypt();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_ready_on_last_wait();
        test_ready_in_issue();
        test_reset_mid_wait();
        test_wrap();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_words: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
